ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- It is the opposite direction of the existing keyboard receive path and shares the same PS2_clk/PS2_data open-drain pads.
- It drives the pads low via output-enables only; the top-level tri-states them.
- It flags rx_inhibit so the receiver ignores bus activity during its own transmission.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_host_tx_if.sv | 14 +
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 100 ++++++++++
 tb/tb_ps2_host_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame size and command byte constants
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  localparam int FRAME_BITS = 10;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] RSP_ACK = 8'hFA;
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status bundle between a requester and the PS/2 transmitter
//   master drives tx_data/tx_valid; slave returns tx_ready, busy, rx_inhibit, done, ack_ok, err
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic rx_inhibit;
  logic done;
  logic ack_ok;
  logic err;
  modport master (output tx_data, tx_valid, input tx_ready, busy, rx_inhibit, done, ack_ok, err);
  modport slave (input tx_data, tx_valid, output tx_ready, busy, rx_inhibit, done, ack_ok, err);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizers for PS/2 clock and data plus clock falling-edge detect
//   in: clk, rst (async active-low), ps2_clk_in, ps2_data_in; out: sync_clk, sync_data, fall
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);
  logic [1:0] clk_ff, data_ff;
  logic prev_clk;
  // Flops reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clk_ff <= 2'b11;
      data_ff <= 2'b11;
      prev_clk <= 1'b1;
    end else begin
      clk_ff <= {clk_ff[0], ps2_clk_in};
      data_ff <= {data_ff[0], ps2_data_in};
      prev_clk <= clk_ff[1];
    end
  assign sync_clk = clk_ff[1];
  assign sync_data = data_ff[1];
  assign fall = prev_clk & ~sync_clk;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter driving open-drain pad enables
//   in: clk, rst (async active-low), ps2_clk_in, ps2_data_in; bus (slave): tx_data/tx_valid in,
//   tx_ready/busy/rx_inhibit/done/ack_ok/err out; out: ps2_clk_oe, ps2_data_oe (1 = pull low)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES = 200,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic clk,
  input  logic rst,
  ps2_host_tx_if.slave bus,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe
);
  localparam int PW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  state_t state;
  logic [FRAME_BITS-1:0] frame;
  logic [3:0] cnt;
  logic [PW-1:0] phase;
  logic sync_clk, sync_data, fall;
  logic done_q, err_q, ack_q;
  ps2_sync_edge u_sync (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .sync_clk(sync_clk),
    .sync_data(sync_data),
    .fall(fall)
  );
  // One phase counter serves the inhibit hold, the request hold and the device watchdog.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      frame <= '0;
      cnt <= '0;
      phase <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE:
          if (bus.tx_valid) begin
            frame <= {1'b1, ~^bus.tx_data, bus.tx_data};
            cnt <= '0;
            phase <= '0;
            ps2_clk_oe <= 1'b1;
            state <= INHIBIT;
          end
        INHIBIT:
          if (phase == PW'(INHIBIT_CYCLES - 1)) begin
            phase <= '0;
            ps2_data_oe <= 1'b1;
            state <= REQ;
          end else phase <= phase + 1'b1;
        REQ:
          if (phase == PW'(REQ_CYCLES - 1)) begin
            phase <= '0;
            ps2_clk_oe <= 1'b0;
            state <= SEND;
          end else phase <= phase + 1'b1;
        SEND, ACK, WAIT_IDLE:
          if (state == SEND && fall) begin
            ps2_data_oe <= ~frame[cnt];
            cnt <= cnt + 4'd1;
            phase <= '0;
            if (cnt == 4'd9) state <= ACK;
          end else if (state == ACK && fall) begin
            ack_q <= ~sync_data;
            phase <= '0;
            state <= WAIT_IDLE;
          end else if (state == WAIT_IDLE && sync_clk && sync_data) begin
            done_q <= 1'b1;
            state <= IDLE;
          end else if (!fall && phase == PW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            err_q <= 1'b1;
            phase <= '0;
            state <= IDLE;
          end else phase <= fall ? '0 : phase + 1'b1;
        default: state <= IDLE;
      endcase
    end
  assign bus.tx_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.rx_inhibit = state != IDLE;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.ack_ok = ack_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model clocking at a 40-cycle half-period
module tb_ps2_host_tx;
  import ps2_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_oe, data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in;
  logic [10:0] s;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int last_fall = 0;
  int d0, e0;
  ps2_host_tx_if bus ();
  ps2_host_tx #(.INHIBIT_CYCLES(20), .REQ_CYCLES(4), .TIMEOUT_CYCLES(500)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(clk_oe),
    .ps2_data_oe(data_oe)
  );
  assign ps2_clk_in = ~(clk_oe | dev_clk_low);
  assign ps2_data_in = ~(data_oe | dev_data_low);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [7:0] b, input bit hold);
    @(negedge clk);
    chk("ready_before_accept", 32'(bus.tx_ready), 1);
    bus.tx_valid = 1'b1;
    bus.tx_data = b;
    @(negedge clk);
    bus.tx_valid = hold;
    bus.tx_data = hold ? 8'h00 : ~b;
  endtask
  task automatic phases();
    int n = 0;
    while (clk_oe && !data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, 20);
    n = 0;
    while (clk_oe && data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("req_len", n, 4);
    chk("clk_released", 32'(clk_oe), 0);
  endtask
  task automatic dev(input int nf, input bit ack, output logic [10:0] smp);
    smp = '0;
    repeat (40) @(negedge clk);
    smp[0] = ps2_data_in;
    for (int k = 1; k <= nf; k++) begin
      if (k == 11) begin
        repeat (20) @(negedge clk);
        dev_data_low = ack;
        repeat (20) @(negedge clk);
      end else if (k == 1) chk("start_until_fall", 32'(data_oe), 1);
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) smp[k[3:0]] = ps2_data_in;
      repeat (40) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(bus.tx_ready), 1);
    #1;
  endtask
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.tx_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_clk_oe", 32'(clk_oe), 0);
    chk("rst_data_oe", 32'(data_oe), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ack_ok", 32'(bus.ack_ok), 0);
    rst = 1'b1;
    // 0xED acked
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_SET_LED, 1'b0);
    chk("busy_after_accept", 32'(bus.busy), 1);
    chk("inhibit_eq_busy", 32'(bus.rx_inhibit), 1);
    phases();
    dev(11, 1'b1, s);
    wait_done();
    chk("ed_bits", 32'(s), 32'(11'b11_11101101_0));
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_err", err_cnt - e0, 0);
    chk("ed_ack_ok", 32'(bus.ack_ok), 1);
    // device stalls after four falls
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h3C, 1'b0);
    phases();
    dev(4, 1'b1, s);
    for (int n = 0; n < 1000 && err_cnt == e0; n++) @(negedge clk);
    #1;
    chk("to_latency", err_cyc - last_fall, 503);
    chk("to_err", err_cnt - e0, 1);
    chk("to_clk_oe", 32'(clk_oe), 0);
    chk("to_data_oe", 32'(data_oe), 0);
    chk("to_ready", 32'(bus.tx_ready), 1);
    repeat (5) @(negedge clk);
    chk("to_err_single", err_cnt - e0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_ack_kept", 32'(bus.ack_ok), 1);
    // 0xF4 nacked
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_ENABLE, 1'b0);
    phases();
    dev(11, 1'b0, s);
    wait_done();
    chk("f4_bits", 32'(s), 32'(11'b10_11110100_0));
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_err", err_cnt - e0, 0);
    chk("f4_ack_ok", 32'(bus.ack_ok), 0);
    // 0x5A with tx_valid/0x00 held throughout, then 0x00 accepted at done
    d0 = done_cnt;
    accept(8'h5A, 1'b1);
    phases();
    dev(11, 1'b1, s);
    wait_done();
    chk("5a_bits", 32'(s), 32'(11'b11_01011010_0));
    chk("5a_done", done_cnt - d0, 1);
    chk("5a_ack_ok", 32'(bus.ack_ok), 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("00_accepted", 32'(clk_oe), 1);
    phases();
    dev(11, 1'b1, s);
    wait_done();
    chk("00_bits", 32'(s), 32'(11'b11_00000000_0));
    chk("00_done", done_cnt - d0, 2);
    // async reset mid-SEND
    accept(8'h00, 1'b0);
    phases();
    dev(3, 1'b1, s);
    chk("pre_rst_data_oe", 32'(data_oe), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_clk_oe", 32'(clk_oe), 0);
    chk("arst_data_oe", 32'(data_oe), 0);
    chk("arst_ready", 32'(bus.tx_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.tx_ready), 1);
    chk("post_rst_ack_ok", 32'(bus.ack_ok), 0);
    // 0xFF acked after reset
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_RESET, 1'b0);
    phases();
    dev(11, 1'b1, s);
    wait_done();
    chk("ff_bits", 32'(s), 32'(11'b11_11111111_0));
    chk("ff_done", done_cnt - d0, 1);
    chk("ff_err", err_cnt - e0, 0);
    chk("ff_ack_ok", 32'(bus.ack_ok), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
